// File: rtl/fcounter_seq.sv
// Measurement sequencer: scans enabled measured clocks through the fcounter,
// captures each count and keeps sticky limit-fail and handshake-timeout flags.
module fcounter_seq #(
  parameter  int NCH    = 4,
  parameter  int N      = 8,
  parameter  int WW     = 12,
  parameter  int SETTLE = 4,
  parameter  int TMO    = 255,
  localparam int SW     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              cont,
  input  logic [NCH-1:0]    ch_en,
  input  logic [WW-1:0]     window,
  input  logic [NCH*N-1:0]  lo_thr,
  input  logic [NCH*N-1:0]  hi_thr,
  input  logic              fail_clr,
  output logic [SW-1:0]     ms_sel,
  output logic              fcounter_ce,
  output logic              fcounter_som,
  input  logic              fcounter_eom,
  input  logic [N-1:0]      fcounter_adata,
  output logic              busy,
  output logic              meas_valid,
  output logic [SW-1:0]     meas_ch,
  output logic [N-1:0]      meas_data,
  output logic [NCH-1:0]    fail,
  output logic              timeout
);

  localparam int STW = $clog2(SETTLE + 1);
  localparam int TW  = $clog2(TMO + 1);
  localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE - 1);
  localparam logic [TW-1:0]  TMO_LAST    = TW'(TMO - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_SELECT, ST_ARM, ST_WAIT_LOW, ST_WINDOW,
    ST_WAIT_EOM, ST_CHECK, ST_RELEASE, ST_NEXT
  } state_t;

  state_t          state_reg;
  logic [STW-1:0]  settle_cnt_reg;
  logic [WW-1:0]   win_cnt_reg;
  logic [TW-1:0]   tmo_cnt_reg;

  logic [N-1:0]    lo_arr [NCH];
  logic [N-1:0]    hi_arr [NCH];
  logic [WW-1:0]   win_eff;
  logic            has_any, has_above;
  logic [SW-1:0]   lowest_ch, next_above_ch;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_thr
      assign lo_arr[gi] = lo_thr[gi*N +: N];
      assign hi_arr[gi] = hi_thr[gi*N +: N];
    end
  endgenerate

  assign win_eff = (window == '0) ? WW'(1) : window;

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    has_any       = 1'b0;
    has_above     = 1'b0;
    lowest_ch     = '0;
    next_above_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        has_any   = 1'b1;
        lowest_ch = SW'(i);
        if (i > int'(ms_sel)) begin
          has_above     = 1'b1;
          next_above_ch = SW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      win_cnt_reg    <= '0;
      tmo_cnt_reg    <= '0;
      ms_sel         <= '0;
      fcounter_ce    <= 1'b0;
      fcounter_som   <= 1'b0;
      busy           <= 1'b0;
      meas_valid     <= 1'b0;
      meas_ch        <= '0;
      meas_data      <= '0;
      fail           <= '0;
      timeout        <= 1'b0;
    end else begin
      fcounter_ce <= 1'b0;
      meas_valid  <= 1'b0;
      // Clear first so a set later in this cycle overrides it.
      if (fail_clr) begin
        fail    <= '0;
        timeout <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if ((start || cont) && has_any) begin
            ms_sel         <= lowest_ch;
            settle_cnt_reg <= '0;
            busy           <= 1'b1;
            state_reg      <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            fcounter_som <= 1'b1;
            state_reg    <= ST_ARM;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        ST_ARM: begin
          fcounter_ce <= 1'b1;
          tmo_cnt_reg <= '0;
          state_reg   <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!fcounter_eom) begin
            fcounter_som <= 1'b0;
            win_cnt_reg  <= '0;
            state_reg    <= ST_WINDOW;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            timeout      <= 1'b1;
            fcounter_som <= 1'b0;
            state_reg    <= ST_RELEASE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ST_WINDOW: begin
          if (win_cnt_reg == win_eff - 1'b1) begin
            fcounter_ce <= 1'b1;
            tmo_cnt_reg <= '0;
            state_reg   <= ST_WAIT_EOM;
          end else begin
            win_cnt_reg <= win_cnt_reg + 1'b1;
          end
        end
        ST_WAIT_EOM: begin
          if (fcounter_eom) begin
            meas_data  <= fcounter_adata;
            meas_ch    <= ms_sel;
            meas_valid <= 1'b1;
            state_reg  <= ST_CHECK;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            timeout      <= 1'b1;
            fcounter_som <= 1'b0;
            state_reg    <= ST_RELEASE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ST_CHECK: begin
          if (meas_data < lo_arr[meas_ch] || meas_data > hi_arr[meas_ch])
            fail[meas_ch] <= 1'b1;
          state_reg <= ST_RELEASE;
        end
        ST_RELEASE: begin
          fcounter_ce <= 1'b1;
          state_reg   <= ST_NEXT;
        end
        ST_NEXT: begin
          if (has_above) begin
            ms_sel         <= next_above_ch;
            settle_cnt_reg <= '0;
            state_reg      <= ST_SELECT;
          end else if (cont && has_any) begin
            ms_sel         <= lowest_ch;
            settle_cnt_reg <= '0;
            state_reg      <= ST_SELECT;
          end else begin
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
